// File: rtl/udma_ts_pkg.sv
// Shared types and constants for the uDMA timestamp-capture front end.
package udma_ts_pkg;

    localparam int unsigned TS_WIDTH     = 28;
    localparam int unsigned CHID_WIDTH   = 4;
    localparam logic [1:0]  DATASIZE_32B = 2'b10;

    typedef struct packed {
        logic [CHID_WIDTH-1:0] ch_id;
        logic [TS_WIDTH-1:0]   ts;
    } ts_word_t;

endpackage

// File: rtl/udma_ts_fifo.sv
// Synchronous FIFO with registered storage, occupancy count and synchronous flush.
module udma_ts_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             do_push_s, do_pop_s;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign data_o  = mem_q[rd_ptr_q];

    // A push at full is accepted only when a pop frees the slot in the same cycle.
    always_comb begin
        do_pop_s  = pop_i & ~empty_o;
        do_push_s = push_i & (~full_o | do_pop_s);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            level_d = level_q + LW'(do_push_s) - LW'(do_pop_s);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (!flush_i && do_push_s) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/udma_ts_capture.sv
// Multi-channel rising-edge timestamp capture feeding the uDMA RX channel.
module udma_ts_capture
    import udma_ts_pkg::*;
#(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          cfg_en_i,
    input  logic                          cfg_clr_i,
    input  logic [NUM_CH-1:0]             ch_i,
    output logic [1:0]                    data_rx_datasize_o,
    output logic [31:0]                   data_rx_o,
    output logic                          data_rx_valid_o,
    input  logic                          data_rx_ready_i,
    output logic                          overflow_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

    logic [NUM_CH-1:0]   sync1_q, sync2_q, sync3_q;
    logic [TS_WIDTH-1:0] cnt_q, cnt_d;
    logic [NUM_CH-1:0]   pend_q, pend_d;
    logic [TS_WIDTH-1:0] ts_q [NUM_CH];
    logic                ovf_q, ovf_d;

    logic [NUM_CH-1:0]   edge_s, cap_s, grant_s, grant_eff_s, drop_s, load_s;
    logic                found_s, push_s, pop_s;
    logic                fifo_full_s, fifo_empty_s;
    ts_word_t            push_word_s;

    assign data_rx_datasize_o = DATASIZE_32B;
    assign data_rx_valid_o    = ~fifo_empty_s;
    assign overflow_o         = ovf_q;

    assign edge_s = sync2_q & ~sync3_q;
    assign cap_s  = edge_s & {NUM_CH{cfg_en_i & ~cfg_clr_i}};
    assign pop_s  = data_rx_ready_i & ~fifo_empty_s;

    // Synchronizers are deliberately untouched by the soft clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
        end else begin
            sync1_q <= ch_i;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    // Fixed priority: lowest pending index wins.
    always_comb begin
        grant_s     = '0;
        push_word_s = '0;
        found_s     = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (pend_q[i] && !found_s) begin
                grant_s[i]        = 1'b1;
                push_word_s.ch_id = CHID_WIDTH'(i);
                push_word_s.ts    = ts_q[i];
                found_s           = 1'b1;
            end else begin
                grant_s[i] = 1'b0;
            end
        end
    end

    // A channel granted this cycle frees its slot, so a new capture there is not a drop.
    always_comb begin
        push_s      = found_s & (~fifo_full_s | pop_s) & ~cfg_clr_i;
        grant_eff_s = grant_s & {NUM_CH{push_s}};
        drop_s      = cap_s & pend_q & ~grant_eff_s;
        load_s      = cap_s & ~drop_s;
        if (cfg_clr_i) begin
            cnt_d  = '0;
            pend_d = '0;
            ovf_d  = 1'b0;
        end else begin
            if (cfg_en_i) begin
                cnt_d = cnt_q + TS_WIDTH'(1);
            end else begin
                cnt_d = cnt_q;
            end
            pend_d = (pend_q & ~grant_eff_s) | load_s;
            ovf_d  = ovf_q | (|drop_s);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            pend_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
        end
    end

    // Per-channel capture registers hold the stamp until the arbiter pushes it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_CH; i++) begin
                ts_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (load_s[i]) begin
                    ts_q[i] <= cnt_q;
                end
            end
        end
    end

    udma_ts_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(ts_word_t))
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (cfg_clr_i),
        .push_i  (push_s),
        .data_i  (push_word_s),
        .pop_i   (pop_s),
        .data_o  (data_rx_o),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .level_o (fifo_level_o)
    );

endmodule
